// File: rtl/ether_stream_arbiter_pkg.sv
// Shared definitions for the Ethernet output-path arbiter.
//   WORD_W      : width of one event word handed to the 12->16 packer
//   GID_W       : width of the GrantId output (covers up to 8 requesters)
//   arb_state_e : one-hot arbiter states
package pct_ether_pkg;

    localparam int WORD_W = 12;
    localparam int GID_W  = 3;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_STREAM = 4'b0010,
        ST_FLUSH  = 4'b0100,
        ST_DONE   = 4'b1000
    } arb_state_e;

endpackage

// File: rtl/ether_stream_arbiter_if.sv
// FIFO-side bundle between the arbiter and its NREQ first-word-fall-through
// event FIFOs.
//   empty   : per-FIFO empty flag, head word valid when low
//   last_in : per-FIFO flag, head word ends its packet
//   data_in : per-FIFO head word, FIFO i at bits [12i+11:12i]
//   rd_en   : per-FIFO pop, at most one bit high
// master = arbiter side (pops), slave = FIFO side.
interface ether_stream_arbiter_if #(
    parameter int NREQ = 4
);
    import pct_ether_pkg::*;

    logic [NREQ-1:0]        empty;
    logic [NREQ-1:0]        last_in;
    logic [NREQ*WORD_W-1:0] data_in;
    logic [NREQ-1:0]        rd_en;

    modport master (input empty, input last_in, input data_in, output rd_en);
    modport slave  (output empty, output last_in, output data_in, input rd_en);

endinterface

// File: rtl/ether_stream_arbiter_rr_pick.sv
// Combinational round-robin search: returns the first FIFO with a valid head
// word, scanning from ptr+1 (mod NREQ) upward, so the last-served FIFO is
// considered last.
//   empty : per-FIFO empty flags
//   ptr   : index of the most recently granted FIFO
//   found : some FIFO is non-empty
//   idx   : index of the winning FIFO (0 when none found)
module rr_pick
    import pct_ether_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  empty,
    input  logic [GID_W-1:0] ptr,
    output logic             found,
    output logic [GID_W-1:0] idx
);

    // Scan offsets from farthest to nearest so the nearest non-empty FIFO
    // after ptr is the final assignment and therefore wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (((int'(ptr) + k) % NREQ) == i && !empty[i]) begin
                    found = 1'b1;
                    idx   = GID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ether_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing the Ethernet packer among NREQ
// FWFT event FIFOs. One grant passes one whole packet (to the Last word, or
// force-terminated at MAXWORDS words). At end of run the packet in flight is
// drained, then a single end_run_out flush pulse is issued.
//   clk, rst     : clock, asynchronous active-high reset
//   fifo         : FIFO bundle (empty/last_in/data_in in, rd_en out)
//   run_end      : 1-clock request to end the run
//   data_out     : word to the packer, valid with strobe_out
//   strobe_out   : data_out valid
//   end_run_out  : 1-clock flush pulse to the packer
//   grant_id     : current / last granted FIFO
//   busy         : arbiter not idle
//   overflow     : sticky, a packet reached MAXWORDS without Last
module ether_stream_arbiter
    import pct_ether_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MAXWORDS = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    ether_stream_arbiter_if.master fifo,
    input  logic                 run_end,
    output logic [WORD_W-1:0]    data_out,
    output logic                 strobe_out,
    output logic                 end_run_out,
    output logic [GID_W-1:0]     grant_id,
    output logic                 busy,
    output logic                 overflow
);

    localparam int              CNT_W   = $clog2(MAXWORDS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXWORDS);

    arb_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               pend_q, pend_d;
    logic [GID_W-1:0]   grant_d;
    logic               ovf_d;
    logic [WORD_W-1:0]  data_d;
    logic               strobe_d;
    logic               end_run_d;

    logic               pick_found;
    logic [GID_W-1:0]   pick_idx;
    logic               sel_empty;
    logic               sel_last;
    logic [WORD_W-1:0]  sel_data;
    logic               pop;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .empty (fifo.empty),
        .ptr   (grant_id),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Head of the granted FIFO.
    always_comb begin
        sel_empty = 1'b1;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == GID_W'(i)) begin
                sel_empty = fifo.empty[i];
                sel_last  = fifo.last_in[i];
                sel_data  = fifo.data_in[i*WORD_W +: WORD_W];
            end
        end
    end

    // Pops happen only while streaming, only from the granted FIFO.
    assign pop     = (state_q == ST_STREAM) && !sel_empty;
    assign cnt_inc = cnt_q + 1'b1;
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        fifo.rd_en = '0;
        for (int i = 0; i < NREQ; i++) begin
            fifo.rd_en[i] = pop && (grant_id == GID_W'(i));
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        grant_d   = grant_id;
        ovf_d     = overflow;
        data_d    = data_out;
        strobe_d  = 1'b0;
        end_run_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_end) pend_d = 1'b1;
                // A pending run end blocks any new grant.
                if (pend_q) begin
                    state_d = ST_FLUSH;
                end else if (pick_found) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (run_end) pend_d = 1'b1;
                if (pop) begin
                    strobe_d = 1'b1;
                    data_d   = sel_data;
                    cnt_d    = cnt_inc;
                    // Last wins over the length limit: a MAXWORDS-long
                    // packet that ends properly is not an overflow.
                    if (sel_last) begin
                        state_d = ST_IDLE;
                    end else if (cnt_inc == CNT_MAX) begin
                        state_d = ST_IDLE;
                        ovf_d   = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                end_run_d = 1'b1;
                pend_d    = 1'b0;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                // Only a run end with every FIFO drained starts a new run.
                if (run_end && (&fifo.empty)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            grant_id    <= GID_W'(NREQ - 1);
            overflow    <= 1'b0;
            data_out    <= '0;
            strobe_out  <= 1'b0;
            end_run_out <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            grant_id    <= grant_d;
            overflow    <= ovf_d;
            data_out    <= data_d;
            strobe_out  <= strobe_d;
            end_run_out <= end_run_d;
        end
    end

endmodule
